fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage that sits directly upstream of the MIPS controller/decoder. It owns the program counter and issues word reads to instruction memory over a req/ready handshake, then holds the fetched instruction for decode until it is accepted. On accept it selects the next PC from the controller's branch, jump and jr decisions: PC+4, branch target, jump target or register target. It also counts retired fetches and flags misaligned register targets.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address (current PC).
- `imem_ready`  in  1  memory returns data this cycle; meaningful only while `imem_req`=1.
- `imem_rdata`  in  32  instruction word, sampled when `imem_req`&`imem_ready`.
- `instr`  out  32  held instruction; opcode = [31:26], funct = [5:0] to the controller.
- `instr_pc`  out  32  PC of `instr`.
- `pc_plus4`  out  32  `instr_pc`+4, the link value for jal/jalr.
- `instr_valid`  out  1  `instr` is valid for decode.
- `instr_accept`  in  1  decode/execute consumes `instr` this cycle.
- `branch`  in  1  controller Branch.
- `branch_taken`  in  1  ALU branch condition is true.
- `jump`  in  1  controller Jump (j/jal).
- `jr`  in  1  controller Jr (jr/jalr).
- `jr_target`  in  32  rs register value.
- `addr_err`  out  1  sticky flag: a misaligned jr target was seen.
- `fetch_count`  out  32  number of accepted instructions.

## Operation
- FSM states: IDLE, FETCH, HOLD.
- IDLE: entered on reset. Moves to FETCH unconditionally on the next cycle.
- FETCH:
  - `imem_req`=1 and `imem_addr`=PC.
  - Request and address stay stable while `imem_ready`=0, for any number of cycles.
  - On `imem_ready`=1: latch `imem_rdata` into `instr` and PC into `instr_pc`; go to HOLD.
- HOLD:
  - `instr_valid`=1 and `imem_req`=0.
  - `imem_ready` is ignored.
  - On `instr_accept`=1: load PC with the next PC, increment `fetch_count`, go to FETCH.
- Redirect inputs (`branch`, `branch_taken`, `jump`, `jr`, `jr_target`) are sampled only in a HOLD cycle with `instr_accept`=1.
- Next-PC priority:
  1. `jr`: `jr_target` with bits[1:0] forced to 00. If `jr_target[1:0]`≠0, set `addr_err`.
  2. `jump`: {pc_plus4[31:28], instr[25:0], 2'b00}.
  3. `branch`&`branch_taken`: pc_plus4 + (sign-extended instr[15:0] << 2).
  4. Otherwise: pc_plus4.
- Arithmetic: all adds are 32-bit modulo 2^32. PC 32'hFFFF_FFFC+4 wraps to 0. `fetch_count` wraps to 0 after 32'hFFFF_FFFF.

## Timing
- Reset values: PC=`RESET_PC`, state=IDLE, `imem_req`=0, `imem_addr`=`RESET_PC`, `instr`=0, `instr_pc`=0, `pc_plus4`=4, `instr_valid`=0, `addr_err`=0, `fetch_count`=0.
- First request is asserted 1 cycle after `rst` deasserts.
- `instr_valid` rises the cycle after the cycle in which `imem_ready`=1.
- The next request is issued the cycle after accept.
- Best-case throughput is 1 instruction per 2 cycles.
- `rst` wins over every event in the same cycle.
- Reset during FETCH abandons the request; a late `imem_ready` is ignored.
- Reset during HOLD drops `instr_valid` the next cycle.
- `jump` and `jr` both high: `jr` wins, and the case is legal.
- `branch_taken` with `branch`=0 has no effect.

## Structure
- Shared package `fetch_pkg` holds:
  - FSM state enum;
  - instruction field bit positions (opcode, funct, imm16, target26), shared with the controller;
  - `RESET_PC` default.
- One combinational sub-module, `next_pc`, implements target computation and the priority mux. Its inputs are `instr`, `pc_plus4` and the redirect signals; its outputs are the next PC and a misalign flag.
- The FSM, PC, instruction hold register and counter live in `fetch_unit`.

## Test plan
- Sequential fetch:
  - Stimulus: `imem_ready`=1 and `instr_accept`=1 always; no redirects.
  - Required response: `imem_addr` = 0, 4, 8, 12 on every second cycle; `fetch_count` = 1, 2, 3, 4.
- Memory stall:
  - Stimulus: `imem_ready`=0 for 3 cycles at PC 0x0.
  - Required response: `imem_req`=1 and address 0x0 held for all 4 cycles; `instr_valid` rises the cycle after ready.
- Branch:
  - Stimulus: instruction at 0x10 with imm16=16'hFFFE, `branch`=1, `branch_taken`=1.
  - Required response: next `imem_addr`=0x0C.
  - Stimulus: same instruction with `branch_taken`=0.
  - Required response: next `imem_addr`=0x14.
- Jump:
  - Stimulus: instruction at 0x3000_0040 with target26=26'h100, `jump`=1.
  - Required response: next `imem_addr`=0x3000_0400.
  - Stimulus: the same cycle also has `jr`=1 and `jr_target`=0x2000.
  - Required response: next `imem_addr`=0x2000.
- Misaligned jr:
  - Stimulus: `jr`=1 with `jr_target`=0x1002.
  - Required response: fetch from 0x1000; `addr_err`=1 and stays 1 until `rst`.
- Reset mid-operation:
  - Stimulus: `rst` asserted in HOLD, then `imem_ready`=1 in the reset cycle.
  - Required response: all outputs at their reset values the next cycle; the first request after release is to `RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM state, instruction field positions and reset PC for the fetch stage
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} fetch_state_t;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM16_MSB  = 15;
    localparam int IMM16_LSB  = 0;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/fetch_unit_next_pc.sv
// next_pc: redirect target computation and priority mux (jr > jump > taken branch > pc+4)
//   instr_i       low 26 bits of the held instruction (target26, containing imm16)
//   pc_plus4_i    link value of the held instruction
//   branch_i, branch_taken_i, jump_i, jr_i, jr_target_i   controller redirect decisions
//   next_pc_o     selected next PC
//   misalign_o    jr selected with a non-word-aligned register target
module next_pc
    import fetch_pkg::*;
(
    input  logic [TARGET_MSB:0] instr_i,
    input  logic [31:0]         pc_plus4_i,
    input  logic                branch_i,
    input  logic                branch_taken_i,
    input  logic                jump_i,
    input  logic                jr_i,
    input  logic [31:0]         jr_target_i,
    output logic [31:0]         next_pc_o,
    output logic                misalign_o
);
    logic [31:0] br_off;
    logic [31:0] jmp_tgt;
    assign br_off  = {{14{instr_i[IMM16_MSB]}}, instr_i[IMM16_MSB:IMM16_LSB], 2'b00};
    assign jmp_tgt = {pc_plus4_i[31:28], instr_i[TARGET_MSB:TARGET_LSB], 2'b00};
    always_comb begin
        next_pc_o  = jr_i ? {jr_target_i[31:2], 2'b00} :
                     jump_i ? jmp_tgt :
                     (branch_i & branch_taken_i) ? pc_plus4_i + br_off : pc_plus4_i;
        misalign_o = jr_i & (|jr_target_i[1:0]);
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches words over req/ready, holds them for decode and redirects on accept
//   clk, rst                      clock, synchronous active-high reset
//   imem_req_o, imem_addr_o       fetch request and address (current PC)
//   imem_ready_i, imem_rdata_i    memory data handshake
//   instr_o, instr_pc_o, pc_plus4_o, instr_valid_o   held instruction to decode
//   instr_accept_i                decode consumes the held instruction
//   branch_i, branch_taken_i, jump_i, jr_i, jr_target_i   redirect decisions, used on accept
//   addr_err_o                    sticky misaligned-jr flag
//   fetch_count_o                 accepted-instruction counter
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        instr_valid_o,
    input  logic        instr_accept_i,
    input  logic        branch_i,
    input  logic        branch_taken_i,
    input  logic        jump_i,
    input  logic        jr_i,
    input  logic [31:0] jr_target_i,
    output logic        addr_err_o,
    output logic [31:0] fetch_count_o
);
    fetch_state_t state_q;
    logic [31:0]  pc_q, pc_d, instr_q, instr_pc_q, fetch_count_q;
    logic         req_q, valid_q, addr_err_q, misalign;
    next_pc u_next_pc (
        .instr_i        (instr_q[TARGET_MSB:0]),
        .pc_plus4_i     (pc_plus4_o),
        .branch_i       (branch_i),
        .branch_taken_i (branch_taken_i),
        .jump_i         (jump_i),
        .jr_i           (jr_i),
        .jr_target_i    (jr_target_i),
        .next_pc_o      (pc_d),
        .misalign_o     (misalign)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            fetch_count_q <= '0;
            req_q         <= 1'b0;
            valid_q       <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                end
                FETCH: if (imem_ready_i) begin
                    instr_q    <= imem_rdata_i;
                    instr_pc_q <= pc_q;
                    req_q      <= 1'b0;
                    valid_q    <= 1'b1;
                    state_q    <= HOLD;
                end
                HOLD: if (instr_accept_i) begin
                    pc_q          <= pc_d;
                    fetch_count_q <= fetch_count_q + 32'd1;
                    addr_err_q    <= addr_err_q | misalign;
                    valid_q       <= 1'b0;
                    req_q         <= 1'b1;
                    state_q       <= FETCH;
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end
    assign imem_req_o    = req_q;
    assign imem_addr_o   = pc_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign pc_plus4_o    = instr_pc_q + 32'd4;
    assign instr_valid_o = valid_q;
    assign addr_err_o    = addr_err_q;
    assign fetch_count_o = fetch_count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_ready = 1'b0, instr_valid, instr_accept = 1'b0;
    logic        branch = 1'b0, branch_taken = 1'b0, jump = 1'b0, jr = 1'b0, addr_err;
    logic [31:0] imem_addr, imem_rdata = '0, instr, instr_pc, pc_plus4, jr_target = '0, fetch_count;
    int          n_cmp = 0;
    int          n_bad = 0;
    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_o     (imem_req),
        .imem_addr_o    (imem_addr),
        .imem_ready_i   (imem_ready),
        .imem_rdata_i   (imem_rdata),
        .instr_o        (instr),
        .instr_pc_o     (instr_pc),
        .pc_plus4_o     (pc_plus4),
        .instr_valid_o  (instr_valid),
        .instr_accept_i (instr_accept),
        .branch_i       (branch),
        .branch_taken_i (branch_taken),
        .jump_i         (jump),
        .jr_i           (jr),
        .jr_target_i    (jr_target),
        .addr_err_o     (addr_err),
        .fetch_count_o  (fetch_count)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic check_reset(input string tag);
        check({tag, " req"}, {31'd0, imem_req}, 32'd0);
        check({tag, " addr"}, imem_addr, 32'h0);
        check({tag, " instr"}, instr, 32'h0);
        check({tag, " instr_pc"}, instr_pc, 32'h0);
        check({tag, " pc_plus4"}, pc_plus4, 32'h4);
        check({tag, " valid"}, {31'd0, instr_valid}, 32'd0);
        check({tag, " addr_err"}, {31'd0, addr_err}, 32'd0);
        check({tag, " count"}, fetch_count, 32'd0);
    endtask
    // From FETCH: return word w, move to HOLD, then accept with the redirect inputs as set
    task automatic fetch_accept(input logic [31:0] w);
        imem_ready = 1'b1;
        imem_rdata = w;
        step();
        step();
    endtask
    initial begin
        step();
        step();
        check_reset("reset");
        rst = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            check("stall req", {31'd0, imem_req}, 32'd1);
            check("stall addr", imem_addr, 32'h0);
            check("stall valid", {31'd0, instr_valid}, 32'd0);
            imem_ready = (i == 3);
            imem_rdata = 32'hDEAD_BEEF;
            if (i < 3) step();
        end
        step();
        check("ready->valid", {31'd0, instr_valid}, 32'd1);
        check("hold req", {31'd0, imem_req}, 32'd0);
        check("hold instr", instr, 32'hDEAD_BEEF);
        check("hold instr_pc", instr_pc, 32'h0);
        check("hold pc_plus4", pc_plus4, 32'h4);
        instr_accept = 1'b1;
        imem_rdata = 32'h0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("seq addr", imem_addr, 32'(4 * k));
            check("seq count", fetch_count, 32'(k));
            check("seq req", {31'd0, imem_req}, 32'd1);
            if (k < 4) step();
        end
        branch = 1'b1;
        branch_taken = 1'b1;
        fetch_accept(32'h1000_FFFE);
        check("branch taken", imem_addr, 32'h0000_000C);
        branch = 1'b0;
        branch_taken = 1'b0;
        fetch_accept(32'h0);
        check("seq to 0x10", imem_addr, 32'h0000_0010);
        branch = 1'b1;
        fetch_accept(32'h1000_FFFE);
        check("branch not taken", imem_addr, 32'h0000_0014);
        branch = 1'b0;
        branch_taken = 1'b1;
        fetch_accept(32'h1000_FFFE);
        check("taken w/o branch", imem_addr, 32'h0000_0018);
        branch_taken = 1'b0;
        jr = 1'b1;
        jr_target = 32'h3000_0040;
        fetch_accept(32'h0);
        check("jr aligned", imem_addr, 32'h3000_0040);
        jr = 1'b0;
        jump = 1'b1;
        fetch_accept(32'h0800_0100);
        check("jump", imem_addr, 32'h3000_0400);
        jr = 1'b1;
        jr_target = 32'h0000_2000;
        fetch_accept(32'h0800_0100);
        check("jr over jump", imem_addr, 32'h0000_2000);
        check("no addr_err yet", {31'd0, addr_err}, 32'd0);
        jump = 1'b0;
        jr_target = 32'h0000_1002;
        fetch_accept(32'h0);
        check("misaligned jr", imem_addr, 32'h0000_1000);
        check("addr_err set", {31'd0, addr_err}, 32'd1);
        jr_target = 32'hFFFF_FFFC;
        fetch_accept(32'h0);
        check("jr to top", imem_addr, 32'hFFFF_FFFC);
        check("addr_err sticky", {31'd0, addr_err}, 32'd1);
        jr = 1'b0;
        fetch_accept(32'h0);
        check("pc wrap", imem_addr, 32'h0);
        check("count", fetch_count, 32'd14);
        instr_accept = 1'b0;
        imem_rdata = 32'h1234_5678;
        step();
        check("pre-reset hold", {31'd0, instr_valid}, 32'd1);
        rst = 1'b1;
        imem_ready = 1'b1;
        step();
        check_reset("mid reset");
        rst = 1'b0;
        step();
        check("post-reset req", {31'd0, imem_req}, 32'd1);
        check("post-reset addr", imem_addr, 32'h0);
        check("post-reset valid", {31'd0, instr_valid}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
